// File: rtl/fft_frame_streamer.sv
// fft_frame_streamer
//   Output end of the 32-point FFT stage. A complete parallel frame of complex
//   bins is captured in one cycle and then streamed out one bin per beat over
//   a valid/ready handshake. The bins come out in natural or even/odd order.
//   An optional analytic-signal (Hilbert) mask can be applied on the way out.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   frame_valid/ready   frame capture handshake (ready only while idle)
//   br_flat, bi_flat    N packed real/imag bins, bin k at [k*W +: W]
//   deint               0 = natural order, 1 = evens then odds (latched at capture)
//   mask_on             apply analytic mask (latched at capture, needs MASK_EN)
//   out_valid/ready     output stream handshake
//   out_re, out_im      emitted bin
//   out_idx             natural index of the emitted bin
//   out_last            final bin of the frame
module fft_frame_streamer #(
    parameter int N       = 32,
    parameter int W       = 32,
    parameter int MASK_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    input  logic [N*W-1:0]       br_flat,
    input  logic [N*W-1:0]       bi_flat,
    input  logic                 deint,
    input  logic                 mask_on,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_re,
    output logic [W-1:0]         out_im,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_last
);

    localparam int   IW           = $clog2(N);
    localparam logic MASK_PRESENT = (MASK_EN != 0);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t              state;
    logic [IW-1:0]       seq;
    logic                deint_l;
    logic                mask_l;
    logic signed [W-1:0] re_buf [N];
    logic signed [W-1:0] im_buf [N];

    logic                cap;
    logic [IW-1:0]       nxt_seq;
    logic [IW-1:0]       nxt_idx;

    // Even/odd order is a left rotation of the sequence counter:
    // seq < N/2 -> 2*seq, otherwise 2*(seq-N/2)+1.
    function automatic logic [IW-1:0] bin_idx(input logic [IW-1:0] s, input logic d);
        return d ? {s[IW-2:0], s[IW-1]} : s;
    endfunction

    // Analytic mask: DC and Nyquist pass, positive bins doubled with
    // wrap-around (no saturation), negative bins zeroed.
    function automatic logic signed [W-1:0] mask_word(input logic signed [W-1:0] v,
                                                      input logic [IW-1:0]       idx,
                                                      input logic                en);
        if (!en || (idx[IW-2:0] == '0)) return v;
        if (!idx[IW-1])                 return {v[W-2:0], 1'b0};
        return '0;
    endfunction

    assign cap     = (state == IDLE) && frame_ready && frame_valid;
    assign nxt_seq = seq + IW'(1);
    assign nxt_idx = bin_idx(nxt_seq, deint_l);

    // Frame buffer: capture stage, data only, no reset needed
    always_ff @(posedge clk) begin
        if (cap) begin
            for (int k = 0; k < N; k++) begin
                re_buf[k] <= br_flat[k*W +: W];
                im_buf[k] <= bi_flat[k*W +: W];
            end
        end
    end

    // Control and output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            seq         <= '0;
            deint_l     <= 1'b0;
            mask_l      <= 1'b0;
            frame_ready <= 1'b0;
            out_valid   <= 1'b0;
            out_re      <= '0;
            out_im      <= '0;
            out_idx     <= '0;
            out_last    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    frame_ready <= 1'b1;
                    if (cap) begin
                        // Bin 0 comes straight from the input bus because the
                        // buffer is written on this same edge; index 0 is
                        // first in both orders and is never altered by the mask.
                        frame_ready <= 1'b0;
                        deint_l     <= deint;
                        mask_l      <= mask_on && MASK_PRESENT;
                        seq         <= '0;
                        state       <= STREAM;
                        out_valid   <= 1'b1;
                        out_re      <= br_flat[W-1:0];
                        out_im      <= bi_flat[W-1:0];
                        out_idx     <= '0;
                        out_last    <= 1'b0;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (seq == IW'(N-1)) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            seq      <= nxt_seq;
                            out_re   <= mask_word(re_buf[nxt_idx], nxt_idx, mask_l);
                            out_im   <= mask_word(im_buf[nxt_idx], nxt_idx, mask_l);
                            out_idx  <= nxt_idx;
                            out_last <= (nxt_seq == IW'(N-1));
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    frame_ready <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    frame_ready <= 1'b0;
                    out_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_streamer.sv
// tb_fft_frame_streamer
//   Scoreboard bench for fft_frame_streamer (N=32, W=32, MASK_EN=1).
//   Expected bins are pushed when a frame is driven and popped on each beat.
module tb_fft_frame_streamer;

    localparam int N = 32;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           frame_valid = 1'b0;
    logic           frame_ready;
    logic [N*W-1:0] br_flat = '0;
    logic [N*W-1:0] bi_flat = '0;
    logic           deint = 1'b0;
    logic           mask_on = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   out_re;
    logic [W-1:0]   out_im;
    logic [4:0]     out_idx;
    logic           out_last;

    always #5 clk = ~clk;

    fft_frame_streamer #(.N(N), .W(W), .MASK_EN(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .br_flat     (br_flat),
        .bi_flat     (bi_flat),
        .deint       (deint),
        .mask_on     (mask_on),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_re      (out_re),
        .out_im      (out_im),
        .out_idx     (out_idx),
        .out_last    (out_last)
    );

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] re;
        logic [31:0] im;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] fr_re [N];
    logic [31:0] fr_im [N];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_idx(input int s, input bit d);
        if (!d)     return s;
        if (s < 16) return 2 * s;
        return 2 * (s - 16) + 1;
    endfunction

    function automatic logic [31:0] model_mask(input logic [31:0] v, input int i, input bit m);
        if (!m || i == 0 || i == 16) return v;
        if (i < 16)                  return v << 1;
        return 32'h0;
    endfunction

    // Load fr_re/fr_im onto the buses and queue the expected stream.
    task automatic push_frame(input bit d, input bit m);
        exp_t e;
        int   i;
        for (int k = 0; k < N; k++) begin
            br_flat[k*W +: W] = fr_re[k];
            bi_flat[k*W +: W] = fr_im[k];
        end
        for (int s = 0; s < N; s++) begin
            i      = model_idx(s, d);
            e.idx  = i[4:0];
            e.re   = model_mask(fr_re[i], i, m);
            e.im   = model_mask(fr_im[i], i, m);
            e.last = (s == N - 1);
            sb.push_back(e);
        end
    endtask

    // Called just after a rising edge; returns at the negedge after capture.
    task automatic send_frame(input bit d, input bit m, input bit keep);
        bit got;
        got = 1'b0;
        push_frame(d, m);
        deint       = d;
        mask_on     = m;
        frame_valid = 1'b1;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (frame_ready) got = 1'b1;
        end
        chk("cap_seen", 64'(got), 64'(1));
        chk("pre_cap_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        if (!keep) frame_valid = 1'b0;
        @(negedge clk);
        chk("post_cap_valid", 64'(out_valid), 64'(1));
        chk("post_cap_ready", 64'(frame_ready), 64'(0));
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 600 && !ok; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) ok = 1'b1;
        end
        chk("stream_done", 64'(ok), 64'(1));
        @(posedge clk); #1;
    endtask

    // Backpressure pattern 1,0,0,1 when bp is set
    bit bp = 1'b0;
    initial begin
        int n;
        n = 0;
        forever begin
            @(posedge clk); #1;
            if (bp) begin
                out_ready = (n % 4 == 0) || (n % 4 == 3);
                n++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Output monitor: scoreboard pop, hold checks, gap tracking
    int          negcnt = 0;
    int          last_neg = 0;
    int          last_gap = 0;
    int          rises = 0;
    int          beats = 0;
    logic        prev_vld = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] h_re, h_im;
    logic [4:0]  h_idx;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            negcnt++;
            if (!rst_n) begin
                prev_vld   = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (out_valid && !prev_vld) begin
                    rises++;
                    last_gap = negcnt - last_neg;
                end
                if (prev_stall) begin
                    chk("hold_vld", 64'(out_valid), 64'(1));
                    chk("hold_re", 64'(out_re), 64'(h_re));
                    chk("hold_im", 64'(out_im), 64'(h_im));
                    chk("hold_idx", 64'(out_idx), 64'(h_idx));
                end
                if (out_valid) chk("busy_ready", 64'(frame_ready), 64'(0));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("extra_beat", 64'(1), 64'(0));
                    end else begin
                        e = sb.pop_front();
                        chk("idx", 64'(out_idx), 64'(e.idx));
                        chk("re", 64'(out_re), 64'(e.re));
                        chk("im", 64'(out_im), 64'(e.im));
                        chk("last", 64'(out_last), 64'(e.last));
                    end
                    beats++;
                    if (out_last) last_neg = negcnt;
                end
                prev_stall = out_valid && !out_ready;
                prev_vld   = out_valid;
                h_re       = out_re;
                h_im       = out_im;
                h_idx      = out_idx;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int r0;
        int b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_ready", 64'(frame_ready), 64'(0));
        chk("rst_re", 64'(out_re), 64'(0));
        chk("rst_idx", 64'(out_idx), 64'(0));
        chk("rst_last", 64'(out_last), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_pre_clk", 64'(frame_ready), 64'(0));
        @(negedge clk);
        chk("ready_after_rst", 64'(frame_ready), 64'(1));
        @(posedge clk); #1;

        // 1: natural order ramp
        for (int k = 0; k < N; k++) begin
            fr_re[k] = 32'(k);
            fr_im[k] = -32'(k);
        end
        send_frame(1'b0, 1'b0, 1'b0);
        wait_done();

        // 2: even/odd order; control changes after capture must not matter
        send_frame(1'b1, 1'b0, 1'b0);
        deint   = 1'b0;
        mask_on = 1'b1;
        wait_done();

        // 3: analytic mask, including wrap on doubling
        for (int k = 0; k < N; k++) begin
            fr_re[k] = 32'd5;
            fr_im[k] = 32'd5;
        end
        fr_re[3] = 32'h4000_0001;
        send_frame(1'b0, 1'b1, 1'b0);
        wait_done();

        // 4: backpressure plus an ignored mid-stream frame_valid pulse
        for (int k = 0; k < N; k++) begin
            fr_re[k] = $urandom;
            fr_im[k] = $urandom;
        end
        bp = 1'b1;
        send_frame(1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        br_flat     = ~br_flat;
        bi_flat     = ~bi_flat;
        frame_valid = 1'b1;
        @(negedge clk);
        chk("mid_ready", 64'(frame_ready), 64'(0));
        @(posedge clk); #1;
        frame_valid = 1'b0;
        wait_done();
        bp = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("no_recapture", 64'(out_valid), 64'(0));

        // 5: back-to-back frames with frame_valid held high
        for (int k = 0; k < N; k++) begin
            fr_re[k] = $urandom;
            fr_im[k] = $urandom;
        end
        send_frame(1'b1, 1'b1, 1'b1);
        r0 = rises;
        for (int k = 0; k < N; k++) begin
            fr_re[k] = 32'h1000 + 32'(k);
            fr_im[k] = $urandom;
        end
        push_frame(1'b0, 1'b0);
        deint   = 1'b0;
        mask_on = 1'b0;
        for (int c = 0; c < 200 && rises == r0; c++) begin
            @(posedge clk); #1;
        end
        frame_valid = 1'b0;
        chk("b2b_seen", 64'(rises - r0), 64'(1));
        wait_done();
        chk("b2b_gap", 64'(last_gap), 64'(3));

        // 6: asynchronous reset mid-frame
        for (int k = 0; k < N; k++) begin
            fr_re[k] = 32'(k);
            fr_im[k] = 32'(k);
        end
        b0 = beats;
        send_frame(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (beats - b0 >= 10) break;
        end
        rst_n = 1'b0;
        #1;
        chk("rst_async_vld", 64'(out_valid), 64'(0));
        chk("rst_async_ready", 64'(frame_ready), 64'(0));
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) begin
            fr_re[k] = 32'd100 + 32'(k);
            fr_im[k] = 32'd200 + 32'(k);
        end
        send_frame(1'b0, 1'b0, 1'b0);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
